// File: rtl/element_attr_collector_pkg.sv
// Shared widths, attribute type codes and FSM encoding for the element attribute collector.
package element_attr_collector_pkg;

   localparam int TYPE_W  = 4;
   localparam int VALUE_W = 32;

   typedef enum logic [TYPE_W-1:0] {
      AttrColor      = 4'd0,
      AttrSize       = 4'd1,
      AttrWidth      = 4'd2,
      AttrHeight     = 4'd3,
      AttrSrc        = 4'd4,
      AttrHref       = 4'd5,
      AttrBackground = 4'd6,
      AttrPadding    = 4'd7,
      AttrMargin     = 4'd8,
      AttrBorder     = 4'd9,
      AttrPosition   = 4'd10,
      AttrEmpty      = 4'd15
   } attr_type_e;

   typedef enum logic [1:0] {
      StIdle,
      StCollect,
      StEmit
   } state_e;

endpackage

// File: rtl/element_attr_collector_attr_slot_select.sv
// Finds the lowest set mask bit at or above a start position; used when ELEM_ATTR_MASK_EN is set.
module attr_slot_select
   import element_attr_collector_pkg::*;
#(
   parameter int NUM_SLOTS = 11
) (
   input  logic [NUM_SLOTS-1:0] mask,
   input  logic [TYPE_W:0]      from,
   output logic                 found,
   output logic [TYPE_W-1:0]    index
);

   always_comb begin
      found = 1'b0;
      index = '0;
      // Scan downwards so the lowest qualifying bit is the last one assigned.
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (mask[i] && (i >= int'(from))) begin
            found = 1'b1;
            index = TYPE_W'(i);
         end
      end
   end

endmodule

// File: rtl/element_attr_collector.sv
// Collects parsed attributes of one element into slots and streams them out one slot per beat.
// Define ELEM_ATTR_MASK_EN to emit only the slots written during the element.
module element_attr_collector
   import element_attr_collector_pkg::*;
#(
   parameter int                 NUM_SLOTS    = 11,
   parameter logic [VALUE_W-1:0] SIZE_DEFAULT = 32'd3
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               elem_start,
   input  logic               attr_valid,
   input  logic [TYPE_W-1:0]  attr_type,
   input  logic [VALUE_W-1:0] attr_value,
   input  logic               elem_end,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [TYPE_W-1:0]  out_type,
   output logic [VALUE_W-1:0] out_value,
   output logic               out_last,
   output logic               busy,
   output logic               err_badtype,
   output logic               err_overrun
);

   function automatic logic [VALUE_W-1:0] slot_reset_value(input int i);
      return (i == int'(AttrSize)) ? SIZE_DEFAULT : '0;
   endfunction

   state_e             state_q, state_d;
   logic [TYPE_W-1:0]  idx_q, idx_d;
   logic [VALUE_W-1:0] slot_q [NUM_SLOTS];
   logic [VALUE_W-1:0] slot_d [NUM_SLOTS];
   logic               badtype_q, badtype_d;
   logic               overrun_q, overrun_d;

   logic               emitting;
   logic               attr_ok;
   logic               cur_found;
   logic [TYPE_W-1:0]  cur_idx;
   logic [TYPE_W-1:0]  next_idx;
   logic               last_beat;

`ifdef ELEM_ATTR_MASK_EN
   logic [NUM_SLOTS-1:0] mask_q, mask_d;
   logic                 nxt_found;

   attr_slot_select #(
      .NUM_SLOTS(NUM_SLOTS)
   ) u_cur_select (
      .mask (mask_q),
      .from ({1'b0, idx_q}),
      .found(cur_found),
      .index(cur_idx)
   );

   attr_slot_select #(
      .NUM_SLOTS(NUM_SLOTS)
   ) u_nxt_select (
      .mask (mask_q),
      .from ({1'b0, cur_idx} + 5'd1),
      .found(nxt_found),
      .index(next_idx)
   );

   // An empty mask yields a single empty-record beat, which is also the last.
   assign last_beat = !cur_found || !nxt_found;
`else
   assign cur_found = 1'b1;
   assign cur_idx   = idx_q;
   assign next_idx  = idx_q + 1'b1;
   assign last_beat = (idx_q == TYPE_W'(NUM_SLOTS - 1));
`endif

   assign attr_ok  = int'(attr_type) < NUM_SLOTS;
   assign emitting = (state_q == StEmit);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      slot_d    = slot_q;
      badtype_d = 1'b0;
      overrun_d = overrun_q;
`ifdef ELEM_ATTR_MASK_EN
      mask_d    = mask_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (elem_start) begin
               for (int i = 0; i < NUM_SLOTS; i++) slot_d[i] = slot_reset_value(i);
`ifdef ELEM_ATTR_MASK_EN
               mask_d = '0;
`endif
               state_d = StCollect;
            end
         end
         StCollect: begin
            if (attr_valid) begin
               if (attr_ok) begin
                  slot_d[attr_type] = attr_value;
`ifdef ELEM_ATTR_MASK_EN
                  mask_d[attr_type] = 1'b1;
`endif
               end else begin
                  badtype_d = 1'b1;
               end
            end
            // Restart takes priority over both a same-cycle write and a same-cycle close.
            if (elem_start) begin
               for (int i = 0; i < NUM_SLOTS; i++) slot_d[i] = slot_reset_value(i);
`ifdef ELEM_ATTR_MASK_EN
               mask_d = '0;
`endif
            end else if (elem_end) begin
               idx_d   = '0;
               state_d = StEmit;
            end
         end
         StEmit: begin
            if (elem_start || attr_valid || elem_end) overrun_d = 1'b1;
            if (out_ready) begin
               if (last_beat) begin
                  idx_d   = '0;
                  state_d = StIdle;
               end else begin
                  idx_d = next_idx;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         badtype_q <= 1'b0;
         overrun_q <= 1'b0;
         for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= slot_reset_value(i);
`ifdef ELEM_ATTR_MASK_EN
         mask_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         badtype_q <= badtype_d;
         overrun_q <= overrun_d;
         slot_q    <= slot_d;
`ifdef ELEM_ATTR_MASK_EN
         mask_q    <= mask_d;
`endif
      end
   end

   assign out_valid   = emitting;
   assign busy        = (state_q != StIdle);
   assign out_type    = !emitting ? '0 : (cur_found ? cur_idx : AttrEmpty);
   assign out_value   = (emitting && cur_found) ? slot_q[cur_idx] : '0;
   assign out_last    = emitting && last_beat;
   assign err_badtype = badtype_q;
   assign err_overrun = overrun_q;

endmodule

// File: tb/tb_element_attr_collector.sv
// Self-checking bench for element_attr_collector: directed scenarios plus randomized elements.
module tb_element_attr_collector;

   localparam int NS = 11;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        elem_start = 1'b0;
   logic        attr_valid = 1'b0;
   logic [3:0]  attr_type = '0;
   logic [31:0] attr_value = '0;
   logic        elem_end = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [3:0]  out_type;
   logic [31:0] out_value;
   logic        out_last;
   logic        busy;
   logic        err_badtype;
   logic        err_overrun;

   element_attr_collector dut (
      .clock      (clock),
      .reset      (reset),
      .elem_start (elem_start),
      .attr_valid (attr_valid),
      .attr_type  (attr_type),
      .attr_value (attr_value),
      .elem_end   (elem_end),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_type   (out_type),
      .out_value  (out_value),
      .out_last   (out_last),
      .busy       (busy),
      .err_badtype(err_badtype),
      .err_overrun(err_overrun)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Reference model: the attribute record as an array of values plus a written flag per type.
   logic [31:0] m_slot [NS];
   bit          m_written [NS];
   bit          m_overrun = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic m_restart();
      for (int i = 0; i < NS; i++) begin
         m_slot[i]    = (i == 1) ? 32'd3 : 32'd0;
         m_written[i] = 1'b0;
      end
   endtask

   task automatic start_elem();
      elem_start = 1'b1;
      tick();
      elem_start = 1'b0;
      m_restart();
   endtask

   task automatic attr(input int t, input logic [31:0] v, input bit with_end);
      attr_valid = 1'b1;
      attr_type  = 4'(t);
      attr_value = v;
      elem_end   = with_end;
      tick();
      attr_valid = 1'b0;
      elem_end   = 1'b0;
      if (t < NS) begin
         m_slot[t]    = v;
         m_written[t] = 1'b1;
      end
      chk("err_badtype", {31'b0, err_badtype}, (t >= NS) ? 32'd1 : 32'd0);
   endtask

   task automatic end_elem();
      elem_end = 1'b1;
      tick();
      elem_end = 1'b0;
   endtask

   task automatic do_reset_checks();
      reset = 1'b1;
      #1;
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_out_type", {28'b0, out_type}, 0);
      chk("rst_out_value", out_value, 0);
      chk("rst_out_last", {31'b0, out_last}, 0);
      chk("rst_err_badtype", {31'b0, err_badtype}, 0);
      chk("rst_err_overrun", {31'b0, err_overrun}, 0);
      m_overrun = 1'b0;
      m_restart();
   endtask

   // mode 0: always ready; 1: random ready; 2: ready held low for 5 cycles at beat 3.
   task automatic emit(input int mode, input bit reset_at4, input bit overrun_at2);
      logic [3:0]  et[$];
      logic [31:0] ev[$];
      int n = 0;
      int cyc = 0;
      int held = 0;
`ifdef ELEM_ATTR_MASK_EN
      for (int t = 0; t < NS; t++)
         if (m_written[t]) begin et.push_back(4'(t)); ev.push_back(m_slot[t]); end
      if (et.size() == 0) begin et.push_back(4'd15); ev.push_back(32'd0); end
`else
      for (int t = 0; t < NS; t++) begin et.push_back(4'(t)); ev.push_back(m_slot[t]); end
`endif
      while (n < et.size() && cyc < 300) begin
         if (reset_at4 && n == 4) begin
            do_reset_checks();
            reset = 1'b0;
            out_ready = 1'b0;
            tick();
            tick();
            chk("post_rst_out_valid", {31'b0, out_valid}, 0);
            chk("post_rst_busy", {31'b0, busy}, 0);
            return;
         end
         if (mode == 0) out_ready = 1'b1;
         else if (mode == 1) out_ready = 1'($urandom_range(0, 1));
         else if (n == 3 && held < 5) begin out_ready = 1'b0; held++; end
         else out_ready = 1'b1;
         chk("out_valid", {31'b0, out_valid}, 1);
         chk("out_type", {28'b0, out_type}, {28'b0, et[n]});
         chk("out_value", out_value, ev[n]);
         chk("out_last", {31'b0, out_last}, (n == et.size() - 1) ? 32'd1 : 32'd0);
         if (overrun_at2 && n == 2) begin elem_start = 1'b1; m_overrun = 1'b1; end
         if (out_ready) n++;
         tick();
         elem_start = 1'b0;
         cyc++;
      end
      out_ready = 1'b0;
      chk("beat_count", n, et.size());
      chk("end_out_valid", {31'b0, out_valid}, 0);
      chk("end_busy", {31'b0, busy}, 0);
      chk("err_overrun", {31'b0, err_overrun}, {31'b0, m_overrun});
   endtask

   initial begin
      m_restart();
      #12;
      do_reset_checks();
      reset = 1'b0;
      tick();

      // Traffic in IDLE is ignored.
      attr_valid = 1'b1; attr_type = 4'd2; attr_value = 32'd55; elem_end = 1'b1;
      tick();
      attr_valid = 1'b0; elem_end = 1'b0;
      chk("idle_busy", {31'b0, busy}, 0);
      chk("idle_out_valid", {31'b0, out_valid}, 0);
      chk("idle_badtype", {31'b0, err_badtype}, 0);

      // Basic record.
      start_elem();
      chk("collect_busy", {31'b0, busy}, 1);
      attr(2, 32'd100, 1'b0);
      attr(0, 32'd7, 1'b0);
      end_elem();
      emit(0, 1'b0, 1'b0);

      // Duplicate overwrite and out-of-range type.
      start_elem();
      attr(2, 32'd5, 1'b0);
      attr(2, 32'd9, 1'b0);
      attr(12, 32'd77, 1'b0);
      tick();
      chk("badtype_one_cycle", {31'b0, err_badtype}, 0);
      end_elem();
      emit(1, 1'b0, 1'b0);

      // Backpressure stall at beat 3 and overrun during EMIT.
      start_elem();
      for (int t = 0; t < 7; t++) attr(t, $urandom, 1'b0);
      end_elem();
      emit(2, 1'b0, 1'b1);
      tick();
      chk("overrun_sticky", {31'b0, err_overrun}, 1);

      // Attribute and close in the same cycle.
      start_elem();
      attr(4, 32'd44, 1'b1);
      emit(0, 1'b0, 1'b0);

      // Restart and close in the same cycle: restart wins.
      start_elem();
      attr(5, 32'd1, 1'b0);
      elem_start = 1'b1; elem_end = 1'b1;
      tick();
      elem_start = 1'b0; elem_end = 1'b0;
      m_restart();
      chk("restart_busy", {31'b0, busy}, 1);
      chk("restart_no_emit", {31'b0, out_valid}, 0);
      tick();
      chk("restart_no_emit2", {31'b0, out_valid}, 0);
      attr(3, 32'd33, 1'b0);
      end_elem();
      emit(0, 1'b0, 1'b0);

      // Empty element.
      start_elem();
      end_elem();
      emit(0, 1'b0, 1'b0);

      // Reset during beat 4, then a default record.
      start_elem();
      for (int t = 0; t < 7; t++) attr(t, $urandom, 1'b0);
      end_elem();
      emit(0, 1'b1, 1'b0);
      start_elem();
      end_elem();
      emit(0, 1'b0, 1'b0);

      // Randomized elements.
      for (int k = 0; k < 25; k++) begin
         int na;
         start_elem();
         na = $urandom_range(0, 8);
         for (int a = 0; a < na; a++) attr($urandom_range(0, 15), $urandom, 1'b0);
         if ($urandom_range(0, 1) == 1) attr($urandom_range(0, 10), $urandom, 1'b1);
         else end_elem();
         emit($urandom_range(0, 1), 1'b0, ($urandom_range(0, 3) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/element_attr_collector.md
ELEMENT_ATTR_COLLECTOR -- requirements
Module: element_attr_collector

Interface
REQ-001 SHALL have parameters: NUM_SLOTS, default 11, number of attribute types held (types 0..10); SIZE_DEFAULT, default 3, reset/default value of slot 1 (size).
REQ-002 SHALL have port: clock  input  1  the only clock; all logic on its rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: elem_start  input  1  one-cycle pulse: a new element begins.
REQ-005 SHALL have port: attr_valid  input  1  one-cycle pulse: attr_type/attr_value hold a parsed attribute.
REQ-006 SHALL have port: attr_type  input  4  attribute type code from the attribute parser.
REQ-007 SHALL have port: attr_value  input  32  attribute value from the attribute parser.
REQ-008 SHALL have port: elem_end  input  1  one-cycle pulse: element closed (">" seen).
REQ-009 SHALL have ports: out_valid output 1, out_ready input 1, out_type output 4, out_value output 32, out_last output 1; serial record stream, one slot per beat.
REQ-010 SHALL have ports: busy output 1 (high in COLLECT or EMIT); err_badtype output 1 (one-cycle pulse); err_overrun output 1 (sticky).

Function
REQ-011 SHALL implement states IDLE, COLLECT, EMIT.
REQ-012 IDLE: elem_start SHALL load all slots with defaults (slot 1 = SIZE_DEFAULT, others 0), clear written mask, go to COLLECT next cycle; attr_valid/elem_end ignored silently.
REQ-013 COLLECT: attr_valid with attr_type < NUM_SLOTS SHALL write attr_value into slot[attr_type] and set its mask bit; duplicate type SHALL overwrite (last wins).
REQ-014 COLLECT: attr_valid with attr_type >= NUM_SLOTS SHALL discard data and pulse err_badtype the following cycle.
REQ-015 COLLECT: elem_start SHALL restart the element (defaults reloaded, mask cleared), staying in COLLECT.
REQ-016 COLLECT: elem_end SHALL go to EMIT with beat index 0; out_valid SHALL assert the cycle after elem_end was sampled.
REQ-017 Simultaneous attr_valid and elem_end SHALL write the attribute first; it appears in the emitted record.
REQ-018 Simultaneous elem_start and elem_end in COLLECT: elem_start SHALL win (restart, no emit).
REQ-019 EMIT: out_valid high; out_type = current slot index; out_value = slot content; outputs SHALL stay stable while out_valid && !out_ready.
REQ-020 EMIT: a beat completes on out_valid && out_ready; index advances; out_last SHALL be high on the final beat; completion of final beat SHALL return to IDLE next cycle with out_valid low.
REQ-021 EMIT: any elem_start, attr_valid or elem_end SHALL be dropped and set err_overrun.
REQ-022 Beat index counter SHALL be 4 bits and never exceed NUM_SLOTS-1.

Reset
REQ-023 reset SHALL asynchronously force: state IDLE, out_valid 0, out_type 0, out_value 0, out_last 0, busy 0, err_badtype 0, err_overrun 0, all slots to defaults, mask 0, index 0.
REQ-024 reset mid-EMIT SHALL abort the record; no further beats after release.

Configuration
REQ-025 Macro ELEM_ATTR_MASK_EN defined: EMIT SHALL output only slots with mask bit set, ascending type order; if mask empty, a single beat with out_type 15, out_value 0, out_last 1.
REQ-026 ELEM_ATTR_MASK_EN undefined: EMIT SHALL output all NUM_SLOTS slots, types 0..10, out_last on type 10; mask register may be omitted.

Structure
REQ-027 Shared package SHALL hold: attribute type width (4), value width (32), type codes 0..10 (color, size, width, height, src, href, background, padding, margin, border, position), empty-record code 15, state encoding.
REQ-028 One sub-module SHALL be natural: attr_slot_select, next-set-bit finder over the mask (used only with ELEM_ATTR_MASK_EN); all else in one module.

Verification
REQ-029 elem_start; attr (2,100); attr (0,7); elem_end; out_ready=1 -> 11 beats, type2=100, type0=7, type1=3, others 0, out_last on type 10 (mask off).
REQ-030 Same with ELEM_ATTR_MASK_EN -> 2 beats: (0,7) then (2,100) last; empty element -> single beat (15,0,last).
REQ-031 attr (2,5) then (2,9) then elem_end -> type 2 emits 9; attr type 12 -> err_badtype pulse, no slot change.
REQ-032 out_ready held 0 for 5 cycles at beat 3 -> out_type/out_value stable, no beat skipped; elem_start during EMIT -> err_overrun=1 and stays 1.
REQ-033 attr_valid and elem_end same cycle -> attribute present in record; elem_start with elem_end same cycle -> no emit, busy stays 1.
REQ-034 reset asserted during beat 4 -> out_valid 0 immediately, state IDLE, err_overrun 0, size slot 3.
